reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 88 ++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Register file with one byte-enabled write port, two registered read ports and a sequential clear.
// Optional write-to-read forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_be,
    input  logic                    rd_en_a,
    input  logic                    rd_en_b,
    input  logic [ADDR_WIDTH-1:0]   r_addr_a,
    input  logic [ADDR_WIDTH-1:0]   r_addr_b,
    output logic [DATA_WIDTH-1:0]   r_data_a,
    output logic [DATA_WIDTH-1:0]   r_data_b,
    input  logic                    clr_req,
    output logic                    busy
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH/8;

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t                             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]              r_ptr, w_ptr_nxt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]   r_mem;
    logic                               w_wr_acc, w_clr_en;
    logic [DATA_WIDTH-1:0]              w_merged, w_rd_a, w_rd_b;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clr_en    = 1'b0;
        w_wr_acc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLEARING;
                    w_ptr_nxt   = '0;
                end else begin
                    w_wr_acc = wr_en;
                end
            end
            CLEARING: begin
                w_clr_en = 1'b1;
                // Hold the pointer on the last entry so it never wraps mid-clear.
                if (r_ptr == ADDR_WIDTH'(DEPTH-1)) w_state_nxt = IDLE;
                else                               w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state == CLEARING);

    for (genvar k = 0; k < NB; k++) begin : g_be
        assign w_merged[8*k +: 8] = w_be[k] ? w_data[8*k +: 8] : r_mem[w_addr][8*k +: 8];
    end

`ifdef REG_FILE_MP_BYPASS_EN
    assign w_rd_a = (w_wr_acc && (w_addr == r_addr_a)) ? w_merged : r_mem[r_addr_a];
    assign w_rd_b = (w_wr_acc && (w_addr == r_addr_b)) ? w_merged : r_mem[r_addr_b];
`else
    assign w_rd_a = r_mem[r_addr_a];
    assign w_rd_b = r_mem[r_addr_b];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_mem    <= '0;
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_clr_en) r_mem[r_ptr]  <= '0;
            if (w_wr_acc) r_mem[w_addr] <= w_merged;
            // Reads sample the array before this edge's clear/write lands.
            if (rd_en_a)  r_data_a <= w_rd_a;
            if (rd_en_b)  r_data_b <= w_rd_b;
        end
    end
endmodule
